delay_line_sched: RTL and testbench
===================================

# delay_line_sched

Round-robin scheduler that shares one fixed-latency shift-register delay line (WIDTH bits, FIFO_LEN stages, synchronous reset, valid after warm-up) between N_REQ requesters. It sequences the line through reset and warm-up, grants at most one requester per cycle, and tags every issued word with its requester ID in a shadow pipeline. Each word leaving the line is returned with the ID of the requester that issued it. It sits between the requester ports and the delay-line instance and fully owns that line's reset and input.

## Interface
- WIDTH, 8, data width of the delay line
- FIFO_LEN, 3, delay-line depth in stages (≥1)
- N_REQ, 4, number of requesters (≥2); ID width IDW = max(1, $clog2(N_REQ))

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  N_REQ  per-requester request
- i_req_data  in  N_REQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH]
- o_req_ready  out  N_REQ  one-hot grant; transfer when valid & ready
- i_flush  in  1  pulse: drain in-flight words, then re-reset the line
- o_line_rst  out  1  reset to the delay line
- o_line_data  out  WIDTH  data into the delay line
- i_line_data  in  WIDTH  delay-line output (last stage)
- i_line_valid  in  1  delay-line valid
- o_rsp_valid  out  1  returned word valid
- o_rsp_id  out  IDW  requester ID of the returned word
- o_rsp_data  out  WIDTH  returned word (= i_line_data)
- o_busy  out  1  high in any state other than RUN
- o_err  out  1  sticky: i_line_valid low while a tagged word exits

## Operation
- States: LINE_RST, WARMUP, RUN, DRAIN.
- rst: state = LINE_RST, rr pointer = N_REQ-1, tag pipe cleared, flush_pend = 0, o_err = 0.
- o_line_rst = rst | (state == LINE_RST).
- LINE_RST lasts exactly 1 cycle, then WARMUP.
- WARMUP: no grants. Go to RUN on the first cycle with i_line_valid = 1.
- RUN: grant the first requester with valid = 1, searching from (ptr+1) mod N_REQ upward with wrap. On grant, ptr = granted index.
- Otherwise o_req_ready = 0 and ptr holds.
- o_line_data = granted requester's data, else 0. The line shifts every cycle regardless.
- Tag pipe: FIFO_LEN stages of {v, id}. Stage 0 takes {grant, id} each cycle; stage k takes stage k-1.
- Returned word: o_rsp_valid = tag[FIFO_LEN-1].v, o_rsp_id = tag[FIFO_LEN-1].id, o_rsp_data = i_line_data. All combinational.
- i_flush (any state except LINE_RST): set flush_pend.
- In RUN with flush_pend: grants are suppressed from that same cycle. Go to DRAIN.
- DRAIN: no grants. When all tag stages have v = 0, go to LINE_RST and clear flush_pend.
- i_flush during WARMUP or DRAIN: absorbed. Takes effect on the next RUN entry, which goes straight to DRAIN.
- o_err set when tag[FIFO_LEN-1].v & ~i_line_valid. Cleared only by rst.
- Responses are never dropped or reordered. No backpressure on the response side.

## Timing
- Reset values: o_req_ready = 0, o_line_rst = 1, o_line_data = 0, o_rsp_valid = 0, o_rsp_id = 0, o_busy = 1, o_err = 0.
- The line needs FIFO_LEN+1 non-reset cycles after o_line_rst falls. First possible grant is cycle FIFO_LEN+2 after rst deasserts (LINE_RST + warm-up).
- Issue-to-response latency is exactly FIFO_LEN cycles: a word granted in cycle t returns with o_rsp_valid in cycle t+FIFO_LEN.
- Throughput: 1 grant per cycle. With N_REQ requesters continuously valid, each is granted every N_REQ cycles.
- o_req_ready depends combinationally on i_req_valid, state and flush_pend. Requesters must not make valid depend on ready.
- Flush latency: DRAIN lasts ≤ FIFO_LEN cycles, followed by 1 LINE_RST cycle and FIFO_LEN+1 WARMUP cycles.
- rst mid-operation: in-flight tags are discarded, no o_rsp_valid the next cycle, o_err cleared.

## Test plan
- Reset release, FIFO_LEN = 3: o_line_rst high for 1 cycle after rst; o_busy high; first o_req_ready in cycle 5 after rst deasserts; no o_rsp_valid before then.
- Single requester 2 issues 0x11, 0x22, 0x33 back-to-back: responses in the same order, each 3 cycles after its grant, id = 2.
- All 4 requesters valid for 8 cycles: grant order 0,1,2,3,0,1,2,3; responses carry ids in that order with the matching data.
- Requesters 1 and 3 valid, last grant = 3: next grant = 1, then 3, then 1. Grants never go to idle requesters.
- i_flush with 3 words in flight: those 3 words return; o_req_ready stays 0; o_line_rst pulses once after the last return; RUN resumes after warm-up.
- Force i_line_valid low while a tagged word exits: o_err = 1 and stays set until rst.

Source files
------------

// File: rtl/delay_line_sched_if.sv
// Requester/response bundle between the requester ports and the delay-line scheduler.
interface delay_line_sched_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]       o_req_ready;
  logic                   o_rsp_valid;
  logic [IDW-1:0]         o_rsp_id;
  logic [WIDTH-1:0]       o_rsp_data;

  // Requester side: drives requests, observes grants and returned words
  modport master (
    output i_req_valid, i_req_data,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
  );

  // Scheduler side
  modport slave (
    input  i_req_valid, i_req_data,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
  );
endinterface

// File: rtl/delay_line_sched.sv
// Round-robin scheduler sharing one fixed-latency delay line between N_REQ
// requesters; an ID shadow pipe tags each word so it returns with its issuer.
module delay_line_sched #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FIFO_LEN = 3,
  parameter int unsigned N_REQ    = 4
) (
  input  logic                clk,
  input  logic                rst,
  delay_line_sched_if.slave   bus,
  input  logic                i_flush,
  output logic                o_line_rst,
  output logic [WIDTH-1:0]    o_line_data,
  input  logic [WIDTH-1:0]    i_line_data,
  input  logic                i_line_valid,
  output logic                o_busy,
  output logic                o_err
);
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {LINE_RST, WARMUP, RUN, DRAIN} state_t;

  state_t             state, state_next;
  logic [IDW-1:0]     ptr;
  logic               flush_pend, flush_pend_next;
  logic [FIFO_LEN-1:0] tag_v;
  logic [IDW-1:0]     tag_id [FIFO_LEN];
  logic               grant_en;
  logic               found;
  logic [IDW-1:0]     grant_id;
  logic [N_REQ-1:0]   grant;
  int unsigned        cand;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = 0;
    grant_en = (state == RUN) && !flush_pend;
    if (grant_en) begin
      for (int unsigned i = 1; i <= N_REQ; i++) begin
        cand = (32'(ptr) + i) % N_REQ;
        if (!found && bus.i_req_valid[IDW'(cand)]) begin
          found    = 1'b1;
          grant_id = IDW'(cand);
        end
      end
    end
  end

  assign grant           = found ? (N_REQ'(1) << grant_id) : '0;
  assign bus.o_req_ready = grant;
  assign o_line_data     = found ? bus.i_req_data[32'(grant_id)*WIDTH +: WIDTH] : '0;

  assign o_line_rst      = rst | (state == LINE_RST);
  assign o_busy          = (state != RUN);
  assign bus.o_rsp_valid = tag_v[FIFO_LEN-1];
  assign bus.o_rsp_id    = tag_id[FIFO_LEN-1];
  assign bus.o_rsp_data  = i_line_data;

  // Next-state logic; a flush raised in the exit cycle of DRAIN stays pending
  always_comb begin
    state_next      = state;
    flush_pend_next = flush_pend | (i_flush && (state != LINE_RST));
    case (state)
      LINE_RST: state_next = WARMUP;
      WARMUP:   if (i_line_valid) state_next = RUN;
      RUN:      if (flush_pend) state_next = DRAIN;
      DRAIN: begin
        if (tag_v == '0) begin
          state_next      = LINE_RST;
          flush_pend_next = i_flush;
        end
      end
      default:  state_next = LINE_RST;
    endcase
  end

  // State, pointer and flush bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LINE_RST;
      ptr        <= IDW'(N_REQ - 1);
      flush_pend <= 1'b0;
    end else begin
      state      <= state_next;
      flush_pend <= flush_pend_next;
      if (found) ptr <= grant_id;
    end
  end

  // Tag shadow pipe, aligned stage-for-stage with the delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k < FIFO_LEN; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= found;
      tag_id[0] <= grant_id;
      for (int k = 1; k < FIFO_LEN; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // Sticky error: a tagged word left the line while it reported invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (tag_v[FIFO_LEN-1] && !i_line_valid) begin
      o_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_delay_line_sched.sv
// Directed bench for delay_line_sched with a behavioural delay-line model.
module tb_delay_line_sched;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned FIFO_LEN = 3;
  localparam int unsigned N_REQ    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_flush = 1'b0;
  logic line_rst;
  logic [WIDTH-1:0] line_din;
  logic [WIDTH-1:0] line_dout;
  logic line_valid;
  logic busy;
  logic err;
  logic force_inv = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  delay_line_sched_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  delay_line_sched #(.WIDTH(WIDTH), .FIFO_LEN(FIFO_LEN), .N_REQ(N_REQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_flush      (i_flush),
    .o_line_rst   (line_rst),
    .o_line_data  (line_din),
    .i_line_data  (line_dout),
    .i_line_valid (line_valid),
    .o_busy       (busy),
    .o_err        (err)
  );

  // Delay-line model: FIFO_LEN stages, valid after FIFO_LEN non-reset cycles of counting
  logic [WIDTH-1:0] line_q [FIFO_LEN];
  int vcnt = 0;
  always @(posedge clk) begin
    if (line_rst) begin
      for (int k = 0; k < FIFO_LEN; k++) line_q[k] <= '0;
      vcnt <= 0;
    end else begin
      line_q[0] <= line_din;
      for (int k = 1; k < FIFO_LEN; k++) line_q[k] <= line_q[k-1];
      if (vcnt < FIFO_LEN) vcnt <= vcnt + 1;
    end
  end
  assign line_dout  = line_q[FIFO_LEN-1];
  assign line_valid = (vcnt == FIFO_LEN) && !force_inv;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic        flush;
    logic [3:0]  ready;
    logic [7:0]  ld;
    logic        rv;
    logic [1:0]  rid;
    logic [7:0]  rd;
    logic        busy;
    logic        lrst;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] vld, input logic [31:0] data,
                             input logic flush, input logic [3:0] ready,
                             input logic [7:0] ld, input logic rv,
                             input logic [1:0] rid, input logic [7:0] rd,
                             input logic bsy, input logic lrst);
    vec_t r;
    r.vld = vld; r.data = data; r.flush = flush; r.ready = ready; r.ld = ld;
    r.rv = rv; r.rid = rid; r.rd = rd; r.busy = bsy; r.lrst = lrst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;

    // Reset release, single-requester burst
    tbl.push_back(v(4'b0100, 32'h00110000, 0, 4'b0000, 8'h00, 0, 0, 8'h00, 1, 1)); // c0
    for (int i = 1; i <= 4; i++)
      tbl.push_back(v(4'b0100, 32'h00110000, 0, 4'b0000, 8'h00, 0, 0, 8'h00, 1, 0));
    tbl.push_back(v(4'b0100, 32'h00110000, 0, 4'b0100, 8'h11, 0, 0, 8'h00, 0, 0)); // c5
    tbl.push_back(v(4'b0100, 32'h00220000, 0, 4'b0100, 8'h22, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b0100, 32'h00330000, 0, 4'b0100, 8'h33, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 2, 8'h11, 0, 0)); // c8
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 2, 8'h22, 0, 0));
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 2, 8'h33, 0, 0));
    // Park the pointer on requester 3, then all four valid for 8 cycles
    tbl.push_back(v(4'b1000, 32'h44000000, 0, 4'b1000, 8'h44, 0, 0, 8'h00, 0, 0)); // c11
    tbl.push_back(v(4'b1111, 32'hA3A2A1A0, 0, 4'b0001, 8'hA0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b1111, 32'hA3A2A1A0, 0, 4'b0010, 8'hA1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b1111, 32'hA3A2A1A0, 0, 4'b0100, 8'hA2, 1, 3, 8'h44, 0, 0));
    tbl.push_back(v(4'b1111, 32'hA3A2A1A0, 0, 4'b1000, 8'hA3, 1, 0, 8'hA0, 0, 0));
    tbl.push_back(v(4'b1111, 32'hB3B2B1B0, 0, 4'b0001, 8'hB0, 1, 1, 8'hA1, 0, 0)); // c16
    tbl.push_back(v(4'b1111, 32'hB3B2B1B0, 0, 4'b0010, 8'hB1, 1, 2, 8'hA2, 0, 0));
    tbl.push_back(v(4'b1111, 32'hB3B2B1B0, 0, 4'b0100, 8'hB2, 1, 3, 8'hA3, 0, 0));
    tbl.push_back(v(4'b1111, 32'hB3B2B1B0, 0, 4'b1000, 8'hB3, 1, 0, 8'hB0, 0, 0));
    // Sparse requesters 1 and 3, last grant was 3
    tbl.push_back(v(4'b1010, 32'hC300C100, 0, 4'b0010, 8'hC1, 1, 1, 8'hB1, 0, 0)); // c20
    tbl.push_back(v(4'b1010, 32'hC300C100, 0, 4'b1000, 8'hC3, 1, 2, 8'hB2, 0, 0));
    tbl.push_back(v(4'b1010, 32'hC300C100, 0, 4'b0010, 8'hC1, 1, 3, 8'hB3, 0, 0));
    tbl.push_back(v(4'b1010, 32'hC300C100, 0, 4'b1000, 8'hC3, 1, 1, 8'hC1, 0, 0));
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 3, 8'hC3, 0, 0)); // c24
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 1, 8'hC1, 0, 0));
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 3, 8'hC3, 0, 0));
    // Flush with three words in flight
    tbl.push_back(v(4'b0001, 32'h000000D0, 0, 4'b0001, 8'hD0, 0, 0, 8'h00, 0, 0)); // c27
    tbl.push_back(v(4'b0001, 32'h000000D1, 0, 4'b0001, 8'hD1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b0001, 32'h000000D2, 1, 4'b0001, 8'hD2, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0000, 8'h00, 1, 0, 8'hD0, 0, 0)); // c30
    tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0000, 8'h00, 1, 0, 8'hD1, 1, 0));
    tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0000, 8'h00, 1, 0, 8'hD2, 1, 0));
    tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0000, 8'h00, 0, 0, 8'h00, 1, 0));
    tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0000, 8'h00, 0, 0, 8'h00, 1, 1)); // c34
    for (int i = 35; i <= 38; i++)
      tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0000, 8'h00, 0, 0, 8'h00, 1, 0));
    tbl.push_back(v(4'b0001, 32'h000000D3, 0, 4'b0001, 8'hD3, 0, 0, 8'h00, 0, 0)); // c39
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(4'b0000, 32'h0,        0, 4'b0000, 8'h00, 1, 0, 8'hD3, 0, 0)); // c42

    // Reset held two cycles; check reset values in the second
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst ready",     32'(bus.o_req_ready), 32'h0);
    chk("rst line_rst",  32'(line_rst),        32'h1);
    chk("rst line_data", 32'(line_din),        32'h0);
    chk("rst rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
    chk("rst rsp_id",    32'(bus.o_rsp_id),    32'h0);
    chk("rst busy",      32'(busy),            32'h1);
    chk("rst err",       32'(err),             32'h0);
    next_cycle();
    rst = 1'b0;

    // Table-driven run, one record per cycle
    for (int c = 0; c < tbl.size(); c++) begin
      bus.i_req_valid = tbl[c].vld;
      bus.i_req_data  = tbl[c].data;
      i_flush         = tbl[c].flush;
      @(negedge clk);
      chk($sformatf("c%0d ready", c),     32'(bus.o_req_ready), 32'(tbl[c].ready));
      chk($sformatf("c%0d line_data", c), 32'(line_din),        32'(tbl[c].ld));
      chk($sformatf("c%0d rsp_valid", c), 32'(bus.o_rsp_valid), 32'(tbl[c].rv));
      if (tbl[c].rv) begin
        chk($sformatf("c%0d rsp_id", c),   32'(bus.o_rsp_id),   32'(tbl[c].rid));
        chk($sformatf("c%0d rsp_data", c), 32'(bus.o_rsp_data), 32'(tbl[c].rd));
      end
      chk($sformatf("c%0d busy", c),      32'(busy),     32'(tbl[c].busy));
      chk($sformatf("c%0d line_rst", c),  32'(line_rst), 32'(tbl[c].lrst));
      chk($sformatf("c%0d err", c),       32'(err),      32'h0);
      next_cycle();
    end
    i_flush = 1'b0;

    // Error: line reports invalid while a tagged word exits
    bus.i_req_valid = 4'b0010;
    bus.i_req_data  = 32'h0000E100;
    @(negedge clk);
    chk("err grant", 32'(bus.o_req_ready), 32'h2);
    next_cycle();
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    repeat (2) next_cycle();
    force_inv = 1'b1;
    @(negedge clk);
    chk("err exit valid", 32'(bus.o_rsp_valid), 32'h1);
    chk("err exit id",    32'(bus.o_rsp_id),    32'h1);
    chk("err exit data",  32'(bus.o_rsp_data),  32'hE1);
    chk("err not yet",    32'(err),             32'h0);
    next_cycle();
    force_inv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("err sticky %0d", i), 32'(err), 32'h1);
      next_cycle();
    end

    // Reset mid-flight: the in-flight word is discarded and err clears
    bus.i_req_valid = 4'b0010;
    bus.i_req_data  = 32'h0000F100;
    @(negedge clk);
    chk("midrst grant", 32'(bus.o_req_ready), 32'h2);
    next_cycle();
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst line_rst", 32'(line_rst), 32'h1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst err",       32'(err),             32'h0);
    chk("midrst rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
    chk("midrst line_rst2", 32'(line_rst),        32'h1);
    chk("midrst busy",      32'(busy),            32'h1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("midrst no rsp %0d", i), 32'(bus.o_rsp_valid), 32'h0);
      chk($sformatf("midrst no ready %0d", i), 32'(bus.o_req_ready), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
